sobel_edge_detect_8bit: RTL

Consumes the 3x3 grey-level windows produced by the matrix generator, one window per `martrix_wr_en` beat. It computes the Sobel gradient magnitude |Gx|+|Gy|, saturates it to 8 bits, and thresholds it to a binary edge flag. Per-frame position counters blank the border pixels and flag frame completion. The block sits between the window generator and the display/frame-buffer writer in the ISP chain.

---
 rtl/isp_pkg.sv | 36 +++
 rtl/sobel_grad_core.sv | 105 ++++++++++
 rtl/sobel_edge_detect_8bit.sv | 102 ++++++++++
 3 files changed

// File: rtl/isp_pkg.sv
// Shared ISP widths, the saturation constant and small arithmetic helpers
// used by the Sobel edge detector.
package isp_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 10;
    localparam int MAG_W  = 11;

    localparam logic [PIX_W-1:0] PIX_MAX = 8'd255;

    // a + 2*mid + b; the largest result is 1020, so GRAD_W bits never overflow
    function automatic logic [GRAD_W-1:0] tap_sum(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] mid,
                                                 input logic [PIX_W-1:0] b);
        return {2'b00, a} + {1'b0, mid, 1'b0} + {2'b00, b};
    endfunction

    // Absolute difference done as compare-then-subtract so nothing ever wraps
    function automatic logic [GRAD_W-1:0] abs_diff(input logic [GRAD_W-1:0] a,
                                                  input logic [GRAD_W-1:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

    function automatic logic [PIX_W-1:0] sat_pix(input logic [MAG_W-1:0] m);
        if (m > MAG_W'(PIX_MAX)) begin
            return PIX_MAX;
        end else begin
            return m[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sobel_grad_core.sv
// Three-stage Sobel arithmetic: partial sums, absolute gradients, then
// saturated magnitude with blanking and threshold compare. Sideband rides along.
module sobel_grad_core
    import isp_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [PIX_W-1:0] p11,
    input  logic [PIX_W-1:0] p12,
    input  logic [PIX_W-1:0] p13,
    input  logic [PIX_W-1:0] p21,
    input  logic [PIX_W-1:0] p23,
    input  logic [PIX_W-1:0] p31,
    input  logic [PIX_W-1:0] p32,
    input  logic [PIX_W-1:0] p33,
    input  logic             blank_in,
    input  logic             last_in,
    input  logic [PIX_W-1:0] thr,
    output logic             valid_out,
    output logic [PIX_W-1:0] edge_data,
    output logic             edge_bin,
    output logic             last_out
);

    logic              v1_r, v2_r;
    logic              blank1_r, blank2_r, last1_r, last2_r;
    logic [GRAD_W-1:0] gxp_r, gxn_r, gyp_r, gyn_r;
    logic [GRAD_W-1:0] agx_r, agy_r;
    logic [MAG_W-1:0]  mag_s;
    logic [PIX_W-1:0]  edge_s;
    logic              bin_s;

    // Stage 1: unsigned partial sums of the two Sobel kernels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r     <= 1'b0;
            blank1_r <= 1'b0;
            last1_r  <= 1'b0;
            gxp_r    <= 10'd0;
            gxn_r    <= 10'd0;
            gyp_r    <= 10'd0;
            gyn_r    <= 10'd0;
        end else begin
            v1_r <= valid_in;
            if (valid_in) begin
                blank1_r <= blank_in;
                last1_r  <= last_in;
                gxp_r    <= tap_sum(p13, p23, p33);
                gxn_r    <= tap_sum(p11, p21, p31);
                gyp_r    <= tap_sum(p31, p32, p33);
                gyn_r    <= tap_sum(p11, p12, p13);
            end
        end
    end

    // Stage 2: absolute horizontal and vertical gradients
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r     <= 1'b0;
            blank2_r <= 1'b0;
            last2_r  <= 1'b0;
            agx_r    <= 10'd0;
            agy_r    <= 10'd0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                blank2_r <= blank1_r;
                last2_r  <= last1_r;
                agx_r    <= abs_diff(gxp_r, gxn_r);
                agy_r    <= abs_diff(gyp_r, gyn_r);
            end
        end
    end

    // Stage 3 combinational part: magnitude, saturation, border mask, threshold
    always_comb begin
        mag_s  = {1'b0, agx_r} + {1'b0, agy_r};
        edge_s = 8'd0;
        if (blank2_r) begin
            edge_s = 8'd0;
        end else begin
            edge_s = sat_pix(mag_s);
        end
        bin_s = (edge_s > thr);
    end

    // Stage 3 output registers; last_out is a single-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            edge_data <= 8'd0;
            edge_bin  <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            valid_out <= v2_r;
            last_out  <= v2_r & last2_r;
            if (v2_r) begin
                edge_data <= edge_s;
                edge_bin  <= bin_s;
            end
        end
    end

endmodule

// File: rtl/sobel_edge_detect_8bit.sv
// Sobel edge detector top: frame position counters, per-frame threshold
// latch, border blanking and frame_done around the gradient pipeline.
module sobel_edge_detect_8bit
    import isp_pkg::*;
#(
    parameter int IMG_WIDTH  = 1600,
    parameter int IMG_HEIGHT = 1200
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             sobel_en,
    input  logic             martrix_wr_en,
    input  logic [PIX_W-1:0] matrix_p11,
    input  logic [PIX_W-1:0] matrix_p12,
    input  logic [PIX_W-1:0] matrix_p13,
    input  logic [PIX_W-1:0] matrix_p21,
    input  logic [PIX_W-1:0] matrix_p22,
    input  logic [PIX_W-1:0] matrix_p23,
    input  logic [PIX_W-1:0] matrix_p31,
    input  logic [PIX_W-1:0] matrix_p32,
    input  logic [PIX_W-1:0] matrix_p33,
    input  logic [PIX_W-1:0] threshold,
    output logic             edge_wr_en,
    output logic [PIX_W-1:0] edge_data,
    output logic             edge_bin,
    output logic             frame_done
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
    localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(0);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [PIX_W-1:0] thr_r;
    logic             accept_s, origin_s, blank_s, last_s;

    // The centre tap has zero weight in both kernels
    logic             unused_s;
    assign unused_s = ^matrix_p22;

    // Position decode of the window being accepted this cycle
    always_comb begin
        accept_s = sobel_en & martrix_wr_en;
        origin_s = (col_r == COL_ZERO) && (row_r == ROW_ZERO);
        blank_s  = (col_r == COL_ZERO) || (col_r == COL_LAST) ||
                   (row_r == ROW_ZERO) || (row_r == ROW_LAST);
        last_s   = (col_r == COL_LAST) && (row_r == ROW_LAST);
    end

    // Raster position counters; dropping sobel_en rewinds to the frame origin
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_r <= COL_ZERO;
            row_r <= ROW_ZERO;
        end else if (!sobel_en) begin
            col_r <= COL_ZERO;
            row_r <= ROW_ZERO;
        end else if (martrix_wr_en) begin
            if (col_r == COL_LAST) begin
                col_r <= COL_ZERO;
                row_r <= (row_r == ROW_LAST) ? ROW_ZERO : row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end
    end

    // Threshold is sampled once per frame so mid-frame changes wait a frame
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            thr_r <= 8'd0;
        end else if (accept_s && origin_s) begin
            thr_r <= threshold;
        end
    end

    sobel_grad_core u_core (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .valid_in  (accept_s),
        .p11       (matrix_p11),
        .p12       (matrix_p12),
        .p13       (matrix_p13),
        .p21       (matrix_p21),
        .p23       (matrix_p23),
        .p31       (matrix_p31),
        .p32       (matrix_p32),
        .p33       (matrix_p33),
        .blank_in  (blank_s),
        .last_in   (last_s),
        .thr       (thr_r),
        .valid_out (edge_wr_en),
        .edge_data (edge_data),
        .edge_bin  (edge_bin),
        .last_out  (frame_done)
    );

endmodule
